// File: rtl/btn_event_gen.sv
// N-channel button conditioner: 2-FF sync, debounce, then press/release/long-press
// and auto-repeat pulse generation per channel. All pulses are registered, one clock wide.
module btn_event_gen #(
    parameter int unsigned N_BTN            = 2,
    parameter bit          ACTIVE_LOW       = 1'b1,
    parameter int unsigned MIN_PULSE_WIDTH  = 100000,
    parameter int unsigned REPEAT_DELAY     = 12500000,
    parameter int unsigned REPEAT_PERIOD    = 2500000,
    parameter int unsigned LONGPRESS_CYCLES = 25000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic [N_BTN-1:0] i_rpt_en,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat,
    output logic [N_BTN-1:0] o_long,
    output logic             o_any
);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned DW = $clog2(MIN_PULSE_WIDTH + 1);
    localparam int unsigned RW = $clog2(RPT_MAX + 1);
    localparam int unsigned HW = (LONGPRESS_CYCLES > 0) ? $clog2(LONGPRESS_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DB_MAX   = DW'(MIN_PULSE_WIDTH - 1);
    localparam logic [RW-1:0] DELAY_C  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PERIOD_C = RW'(REPEAT_PERIOD);
    localparam logic [HW-1:0] LONG_C   = HW'(LONGPRESS_CYCLES);
    localparam bit            LONG_EN  = (LONGPRESS_CYCLES != 0);

    typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;

    logic [N_BTN-1:0] pulse_nxt;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [1:0]    sync_q;
        logic [DW-1:0] db_cnt_q;
        logic [HW-1:0] hold_cnt_q;
        logic [RW-1:0] rpt_cnt_q;
        logic          btn_q, long_done_q;
        logic          press_q, release_q, repeat_q, long_q;
        state_e        state_q;

        logic          p, accept, rise, fall, long_hit, rep_hit;
        logic [HW-1:0] hold_nxt;
        logic [RW-1:0] rpt_nxt;

        assign p        = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];
        assign accept   = (p != btn_q) && (db_cnt_q == DB_MAX);
        assign rise     = accept & p;
        assign fall     = accept & ~p;
        assign hold_nxt = (hold_cnt_q == LONG_C) ? hold_cnt_q : hold_cnt_q + HW'(1);
        assign rpt_nxt  = rpt_cnt_q + RW'(1);
        assign long_hit = LONG_EN && (state_q != StIdle) && !long_done_q
                          && (hold_nxt == LONG_C);
        assign rep_hit  = i_rpt_en[g]
                          && (((state_q == StHeld) && (rpt_nxt == DELAY_C))
                           || ((state_q == StRepeat) && (rpt_nxt == PERIOD_C)));
        // Release beats any repeat/long pulse falling in the same cycle.
        assign pulse_nxt[g] = fall | rise | (~fall & (long_hit | rep_hit));

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                sync_q      <= {2{ACTIVE_LOW}};
                db_cnt_q    <= '0;
                btn_q       <= 1'b0;
                state_q     <= StIdle;
                hold_cnt_q  <= '0;
                rpt_cnt_q   <= '0;
                long_done_q <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                repeat_q    <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                sync_q    <= {sync_q[0], i_btn[g]};
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                long_q    <= 1'b0;

                if (p == btn_q) begin
                    db_cnt_q <= '0;
                end else if (accept) begin
                    btn_q    <= p;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DW'(1);
                end

                if (fall) begin
                    release_q   <= 1'b1;
                    state_q     <= StIdle;
                    hold_cnt_q  <= '0;
                    rpt_cnt_q   <= '0;
                    long_done_q <= 1'b0;
                end else begin
                    case (state_q)
                        StIdle: begin
                            if (rise) begin
                                press_q     <= 1'b1;
                                state_q     <= StHeld;
                                hold_cnt_q  <= '0;
                                rpt_cnt_q   <= '0;
                                long_done_q <= 1'b0;
                            end
                        end
                        StHeld, StRepeat: begin
                            hold_cnt_q <= hold_nxt;
                            if (long_hit) begin
                                long_q      <= 1'b1;
                                long_done_q <= 1'b1;
                            end
                            if (!i_rpt_en[g]) begin
                                rpt_cnt_q <= '0;
                                state_q   <= StHeld;
                            end else if (rep_hit) begin
                                repeat_q  <= 1'b1;
                                rpt_cnt_q <= '0;
                                state_q   <= StRepeat;
                            end else begin
                                rpt_cnt_q <= rpt_nxt;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end

        assign o_btn[g]     = btn_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_repeat[g]  = repeat_q;
        assign o_long[g]    = long_q;
    end

    logic any_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |pulse_nxt;
        end
    end

    assign o_any = any_q;

endmodule
